// File: rtl/lstm_q_pkg.sv
// rtl/lstm_q_pkg.sv - shared LSTM quantisation constants, mode encoding and product width
package lstm_q_pkg;

  // Activation mode carried with each beat
  typedef enum logic {
    MODE_SIGMOID = 1'b0,
    MODE_TANH    = 1'b1
  } mode_e;

  // Default quantisation scales and zero points
  localparam int DEF_ACC_W         = 32;
  localparam int DEF_OUT_W         = 8;
  localparam int DEF_SCALE_DATA    = 128;
  localparam int DEF_SCALE_W       = 128;
  localparam int DEF_SCALE_B       = 256;
  localparam int DEF_ZERO_B        = 0;
  localparam int DEF_SCALE_SIGMOID = 24;
  localparam int DEF_SCALE_TANH    = 48;
  localparam int DEF_ZERO_SIGMOID  = 128;
  localparam int DEF_ZERO_TANH     = 128;

  // Products are carried this many bits wider than the accumulator
  localparam int PROD_GUARD = 11;
  localparam int PROD_W     = DEF_ACC_W + PROD_GUARD;

endpackage

// File: rtl/bqs_lane.sv
// rtl/bqs_lane.sv - one requantiser lane: products, truncating divide, clamp
module bqs_lane
  import lstm_q_pkg::*;
#(
  parameter int ACC_W         = DEF_ACC_W,
  parameter int OUT_W         = DEF_OUT_W,
  parameter int SCALE_DATA    = DEF_SCALE_DATA,
  parameter int SCALE_W       = DEF_SCALE_W,
  parameter int SCALE_B       = DEF_SCALE_B,
  parameter int ZERO_B        = DEF_ZERO_B,
  parameter int SCALE_SIGMOID = DEF_SCALE_SIGMOID,
  parameter int SCALE_TANH    = DEF_SCALE_TANH,
  parameter int ZERO_SIGMOID  = DEF_ZERO_SIGMOID,
  parameter int ZERO_TANH     = DEF_ZERO_TANH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld1_i,
  input  logic                    ld2_i,
  input  logic                    ld3_i,
  input  logic                    mode_in_i,
  input  logic                    mode_p1_i,
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic [7:0]              bias_i,
  output logic [OUT_W-1:0]        code_o,
  output logic                    sat_o
);

  localparam int PW     = ACC_W + PROD_GUARD;
  localparam int DIV_A  = SCALE_W * SCALE_DATA;
  localparam int SH_A   = $clog2(DIV_A);
  localparam bit POW2_A = (DIV_A == (1 << SH_A));
  localparam int SH_B   = $clog2(SCALE_B);
  localparam bit POW2_B = (SCALE_B == (1 << SH_B));

  typedef logic signed [PW-1:0] wide_t;

  localparam wide_t S_SIG    = wide_t'(SCALE_SIGMOID);
  localparam wide_t S_TANH   = wide_t'(SCALE_TANH);
  localparam wide_t Z_SIG    = wide_t'(ZERO_SIGMOID);
  localparam wide_t Z_TANH   = wide_t'(ZERO_TANH);
  localparam wide_t ZB       = wide_t'(ZERO_B);
  localparam wide_t DA       = wide_t'(DIV_A);
  localparam wide_t DB       = wide_t'(SCALE_B);
  localparam wide_t CODE_MAX = wide_t'((1 << OUT_W) - 1);

  // Signed division truncating toward zero; a power-of-two divisor becomes a
  // shift, with negative values biased up first so the shift does not floor.
  function automatic wide_t div_tz(input wide_t x, input wide_t d, input int sh, input bit pow2);
    wide_t r;
    if (pow2) begin
      if (x[PW-1]) r = (x + (d - wide_t'(1))) >>> sh;
      else         r = x >>> sh;
    end else begin
      r = x / d;
    end
    return r;
  endfunction

  wide_t prod_a_d, prod_a_q, prod_b_d, prod_b_q;
  wide_t sum_d, sum_q;
  wide_t s_sel, z_sel;
  logic  sat_lo, sat_hi;
  logic [OUT_W-1:0] code_d, code_q;

  // P1 inputs: scale selected by the mode of the incoming beat
  always_comb begin
    s_sel    = (mode_in_i == MODE_TANH) ? S_TANH : S_SIG;
    prod_a_d = wide_t'(acc_i) * s_sel;
    prod_b_d = (wide_t'({1'b0, bias_i}) - ZB) * s_sel;
  end

  // P2 inputs: divided terms plus zero point of the beat held in P1
  always_comb begin
    z_sel = (mode_p1_i == MODE_TANH) ? Z_TANH : Z_SIG;
    sum_d = div_tz(prod_a_q, DA, SH_A, POW2_A) + div_tz(prod_b_q, DB, SH_B, POW2_B) + z_sel;
  end

  // P3 inputs: clamp the unsaturated sum into the unsigned code range
  always_comb begin
    sat_lo = sum_q[PW-1];
    sat_hi = !sat_lo && (sum_q > CODE_MAX);
    if (sat_lo)      code_d = '0;
    else if (sat_hi) code_d = '1;
    else             code_d = sum_q[OUT_W-1:0];
  end

  // Pipeline registers; each stage loads only when a valid beat moves into it
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_a_q <= '0;
      prod_b_q <= '0;
      sum_q    <= '0;
      code_q   <= '0;
    end else begin
      if (ld1_i) begin
        prod_a_q <= prod_a_d;
        prod_b_q <= prod_b_d;
      end
      if (ld2_i) sum_q  <= sum_d;
      if (ld3_i) code_q <= code_d;
    end
  end

  assign code_o = code_q;
  assign sat_o  = sat_lo || sat_hi;

endmodule

// File: rtl/bqs_requant_pipe.sv
// rtl/bqs_requant_pipe.sv - multi-lane pipelined bias/quantise/saturate stage (optional BQS_SAT_CNT_EN)
module bqs_requant_pipe
  import lstm_q_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int ACC_W         = DEF_ACC_W,
  parameter int OUT_W         = DEF_OUT_W,
  parameter int SCALE_DATA    = DEF_SCALE_DATA,
  parameter int SCALE_W       = DEF_SCALE_W,
  parameter int SCALE_B       = DEF_SCALE_B,
  parameter int ZERO_B        = DEF_ZERO_B,
  parameter int SCALE_SIGMOID = DEF_SCALE_SIGMOID,
  parameter int SCALE_TANH    = DEF_SCALE_TANH,
  parameter int ZERO_SIGMOID  = DEF_ZERO_SIGMOID,
  parameter int ZERO_TANH     = DEF_ZERO_TANH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_mode,
  input  logic [NUM_CH*ACC_W-1:0]   in_acc,
  input  logic [NUM_CH*8-1:0]       in_bias,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_mode,
  output logic [NUM_CH*OUT_W-1:0]   out_code
`ifdef BQS_SAT_CNT_EN
  ,
  output logic [15:0]               sat_cnt,
  input  logic                      sat_clr
`endif
);

  logic en;
  logic v1_q, v2_q, v3_q;
  logic m1_q, m2_q, m3_q;
`ifdef BQS_SAT_CNT_EN
  logic [NUM_CH-1:0] lane_sat;
`else
  logic [NUM_CH-1:0] lane_sat_unused;
`endif

  // Whole pipe advances together whenever the output slot is free or draining
  assign en        = !v3_q || out_ready;
  assign in_ready  = en;
  assign out_valid = v3_q;
  assign out_mode  = m3_q;

  // Valid and mode shift register; bubbles travel as cleared valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      m1_q <= 1'b0;
      m2_q <= 1'b0;
      m3_q <= 1'b0;
    end else if (en) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (in_valid) m1_q <= in_mode;
      if (v1_q)     m2_q <= m1_q;
      if (v2_q)     m3_q <= m2_q;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    bqs_lane #(
      .ACC_W        (ACC_W),
      .OUT_W        (OUT_W),
      .SCALE_DATA   (SCALE_DATA),
      .SCALE_W      (SCALE_W),
      .SCALE_B      (SCALE_B),
      .ZERO_B       (ZERO_B),
      .SCALE_SIGMOID(SCALE_SIGMOID),
      .SCALE_TANH   (SCALE_TANH),
      .ZERO_SIGMOID (ZERO_SIGMOID),
      .ZERO_TANH    (ZERO_TANH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .ld1_i    (en && in_valid),
      .ld2_i    (en && v1_q),
      .ld3_i    (en && v2_q),
      .mode_in_i(in_mode),
      .mode_p1_i(m1_q),
      .acc_i    (in_acc[gi*ACC_W +: ACC_W]),
      .bias_i   (in_bias[gi*8 +: 8]),
      .code_o   (out_code[gi*OUT_W +: OUT_W]),
`ifdef BQS_SAT_CNT_EN
      .sat_o    (lane_sat[gi])
`else
      .sat_o    (lane_sat_unused[gi])
`endif
    );
  end

`ifdef BQS_SAT_CNT_EN
  logic [15:0] sat_cnt_d, sat_cnt_q;

  // Add the clamped lanes of the beat entering P3; clear wins, count sticks at max
  always_comb begin
    logic [16:0] acc_v;
    acc_v = {1'b0, sat_cnt_q};
    if (en && v2_q) begin
      for (int i = 0; i < NUM_CH; i++) acc_v = acc_v + 17'(lane_sat[i]);
    end
    sat_cnt_d = acc_v[16] ? 16'hFFFF : acc_v[15:0];
    if (sat_clr) sat_cnt_d = 16'h0000;
  end

  // Saturation event counter register
  always_ff @(posedge clk) begin
    if (rst) sat_cnt_q <= 16'h0000;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_bqs_requant_pipe.sv
// tb/tb_bqs_requant_pipe.sv - randomized scoreboard bench for bqs_requant_pipe
module tb_bqs_requant_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_mode;
  logic [127:0] in_acc;
  logic [31:0]  in_bias;
  logic         out_valid, out_ready, out_mode;
  logic [31:0]  out_code;
`ifdef BQS_SAT_CNT_EN
  logic [15:0]  sat_cnt;
  logic         sat_clr;
`endif

  always #5 clk = ~clk;

  bqs_requant_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_acc   (in_acc),
    .in_bias  (in_bias),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mode (out_mode),
    .out_code (out_code)
`ifdef BQS_SAT_CNT_EN
    ,
    .sat_cnt  (sat_cnt),
    .sat_clr  (sat_clr)
`endif
  );

  typedef struct {
    logic [31:0] code;
    logic        mode;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          accept_cnt = 0;
  int          sat_exp = 0;
  int          rdy_mode = 0;
  bit          cur_lit_en = 0;
  logic [7:0]  cur_lit = 0;
  bit          cur_chk_lat = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_code = 0;
  logic        prev_mode = 0;

  // Reference: plain integer arithmetic; SV '/' on longint truncates toward zero
  function automatic longint unsat_of(input longint acc, input longint bias, input bit mode);
    longint s;
    s = mode ? 48 : 24;
    return (acc * s) / (128 * 128) + ((bias - 0) * s) / 256 + 128;
  endfunction

  function automatic logic [7:0] clamp8(input longint u);
    if (u < 0)   return 8'd0;
    if (u > 255) return 8'd255;
    return 8'(u);
  endfunction

  task automatic check(input string name, input longint got, input longint want);
    n_vec++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream readiness pattern
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard: record accepted beats, compare delivered beats, watch stalls
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      sat_exp    = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_code_stable", out_code, prev_code);
        check("stall_mode_stable", out_mode, prev_mode);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_code", out_code, e.code);
          check("out_mode", out_mode, e.mode);
          if (e.chk_lat) check("latency", cyc + 1 - e.acc_cyc, 3);
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
          longint u;
          logic [31:0] a;
          a = in_acc[i*32 +: 32];
          u = unsat_of(longint'($signed(a)), longint'(in_bias[i*8 +: 8]), in_mode);
          if (u < 0 || u > 255) sat_exp++;
          if (cur_lit_en) begin
            check("model_pin", clamp8(u), cur_lit);
            e.code[i*8 +: 8] = cur_lit;
          end else begin
            e.code[i*8 +: 8] = clamp8(u);
          end
        end
        e.mode    = in_mode;
        e.acc_cyc = cyc + 1;
        e.chk_lat = cur_chk_lat;
        exp_q.push_back(e);
        accept_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_code  = out_code;
      prev_mode  = out_mode;
    end
  end

  // Offer one beat (called just after a rising edge); returns just after the accepting edge
  task automatic send(input bit mode, input logic [127:0] acc, input logic [31:0] bias);
    bit done;
    int guard;
    in_valid = 1'b1;
    in_mode  = mode;
    in_acc   = acc;
    in_bias  = bias;
    done  = 0;
    guard = 0;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (!done && guard > 300) begin
        check("accept_timeout", 0, 1);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int g;
    in_valid = 1'b0;
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_acc();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($signed(32'($urandom_range(0, 40000))) - 20000);
      2:       return 32'($signed(32'($urandom_range(0, 600000))) - 300000);
      default: return 32'($signed(32'($urandom_range(0, 400))) - 200);
    endcase
  endfunction

  task automatic send_random();
    logic [127:0] a;
    logic [31:0]  b;
    for (int i = 0; i < 4; i++) a[i*32 +: 32] = rand_acc();
    b = $urandom;
    send(1'($urandom_range(0, 1)), a, b);
  endtask

  int          d_acc  [9] = '{0, 163840, -98304, 0, -100, 16384, 16384, 16384, 16384};
  logic [7:0]  d_bias [9] = '{8'd0, 8'd0, 8'd0, 8'd128, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  bit          d_mode [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
  logic [7:0]  d_code [9] = '{8'd128, 8'd255, 8'd0, 8'd140, 8'd128, 8'd152, 8'd176, 8'd152, 8'd176};

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_mode  = 1'b0;
    in_acc   = '0;
    in_bias  = '0;
`ifdef BQS_SAT_CNT_EN
    sat_clr  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_code", out_code, 0);
    check("reset_out_mode", out_mode, 0);
`ifdef BQS_SAT_CNT_EN
    check("reset_sat_cnt", sat_cnt, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed beats with hand-computed codes, back to back at full rate
    cur_lit_en  = 1;
    cur_chk_lat = 1;
    for (int k = 0; k < 9; k++) begin
      cur_lit = d_code[k];
      send(d_mode[k], {4{32'(d_acc[k])}}, {4{d_bias[k]}});
    end
    drain();
    cur_lit_en  = 0;
    cur_chk_lat = 0;
`ifdef BQS_SAT_CNT_EN
    check("sat_cnt_directed", sat_cnt, sat_exp);
    check("sat_cnt_directed_lit", sat_cnt, 8);
    sat_clr = 1'b1;
    idle(1);
    sat_clr = 1'b0;
    @(negedge clk);
    check("sat_cnt_clear", sat_cnt, 0);
    sat_exp = 0;
    @(posedge clk);
    #1;
`endif

    // Eight back-to-back beats against a randomly stalling consumer
    rdy_mode = 1;
    for (int k = 0; k < 8; k++) send_random();
    drain();

    // Longer random run with occasional bubbles
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send_random();
    end
    rdy_mode = 0;
    drain();
`ifdef BQS_SAT_CNT_EN
    check("sat_cnt_random", sat_cnt, sat_exp);
`endif

    // Reset with three beats in flight
    rdy_mode = 2;
    idle(2);
    for (int k = 0; k < 3; k++) send(1'b0, {4{32'd163840}}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    check("reset_flush_out_valid", out_valid, 0);
`ifdef BQS_SAT_CNT_EN
    check("reset_flush_sat_cnt", sat_cnt, 0);
`endif
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_output_after_reset", out_valid, 0);
    end
    check("queue_empty_after_reset", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/bqs_requant_pipe.md
# bqs_requant_pipe

Pipelined, multi-lane bias/quantise/saturate stage for the LSTM gate datapath. It takes `NUM_CH` 32-bit inner-product accumulators and their 8-bit quantised biases per beat, and rescales each into the activation LUT's input domain. The mode is selected per beat: sigmoid or tanh. Each result is offset by the activation zero point and clamped to an unsigned 8-bit code. It sits between the MAC accumulator registers and the sigmoid/tanh LUTs, and replaces the single-lane combinational requantiser with a valid/ready pipelined unit.

## Interface
- `NUM_CH`, 4: lanes per beat.
- `ACC_W`, 32: signed accumulator width.
- `OUT_W`, 8: unsigned output code width.
- `SCALE_DATA`, 128: scale of Xt/Ht.
- `SCALE_W`, 128: weight scale.
- `SCALE_B`, 256: bias scale.
- `ZERO_B`, 0: bias zero point.
- `SCALE_SIGMOID`, 24: sigmoid input scale.
- `SCALE_TANH`, 48: tanh input scale.
- `ZERO_SIGMOID`, 128: sigmoid input zero point.
- `ZERO_TANH`, 128: tanh input zero point.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  beat offered.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_mode`  in  1  0 = sigmoid, 1 = tanh.
- `in_acc`  in  `NUM_CH*ACC_W`  signed accumulators; lane i at `[i*ACC_W +: ACC_W]`.
- `in_bias`  in  `NUM_CH*8`  unsigned bias codes.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  downstream accepts.
- `out_mode`  out  1  mode carried with the beat.
- `out_code`  out  `NUM_CH*OUT_W`  saturated codes.
- `sat_cnt`  out  16  saturation event count (only with `BQS_SAT_CNT_EN`).
- `sat_clr`  in  1  clears `sat_cnt` (only with `BQS_SAT_CNT_EN`).

## Operation
- Per lane, with S = SCALE_SIGMOID or SCALE_TANH and Z = ZERO_SIGMOID or ZERO_TANH chosen by the beat's mode:
  - Term A = (acc·S) / (SCALE_W·SCALE_DATA).
  - Term B = ((bias − ZERO_B)·S) / SCALE_B.
  - Unsat = A + B + Z.
- Arithmetic rules:
  - All products are held at `ACC_W+11` bits or more, signed.
  - Division is signed and truncates toward zero, not floor. A power-of-two shift is only legal with a negative-value correction.
- Saturation: unsat < 0 → 0; unsat > 2^OUT_W−1 → 2^OUT_W−1; otherwise unsat[OUT_W−1:0].
- Mode is captured with the beat and travels down the pipe. Consecutive beats may have different modes.
- Pipeline has three stages:
  - P1 registers the products.
  - P2 registers the divided sum.
  - P3 registers the clamped code plus valid and mode.
- Flow control:
  - Advance enable `en = !out_valid || out_ready`. All stages shift together when `en` is high and hold otherwise.
  - `in_ready = en`, which is combinational from `out_ready` and `out_valid`.
  - Bubbles propagate as invalid stages.
  - `out_code`/`out_mode` stay stable while `out_valid && !out_ready`.

## Timing
- Latency is 3 cycles from accept to `out_valid`, with no stalls.
- Throughput is 1 beat/cycle while `out_ready` stays high.
- Reset values:
  - `out_valid` = 0, `out_code` = 0, `out_mode` = 0, `sat_cnt` = 0.
  - All internal valid bits = 0.
  - `in_ready` is 1 in the cycle after reset.
- Reset mid-operation discards every in-flight beat. No output is produced for them.
- Accept and output-drain in the same cycle is legal. The pipe stays full at 1 beat/cycle.
- `in_valid` low with `en` high inserts a bubble. Data on the inputs is ignored when `in_valid` is low.

## Configuration
- `BQS_SAT_CNT_EN` defined:
  - `sat_cnt` increments by the number of lanes clamped (either direction) in each beat, counted at the P3 load.
  - The counter saturates at 0xFFFF.
  - `sat_clr` has priority over the increment.
- `BQS_SAT_CNT_EN` undefined: the `sat_cnt`/`sat_clr` ports and the counter logic are absent.

## Structure
- Shared package `lstm_q_pkg` holds:
  - the mode encoding (`MODE_SIGMOID` = 0, `MODE_TANH` = 1);
  - the default scale/zero-point constants;
  - the product-width localparam.
- Sub-module `bqs_lane` contains one lane's P1/P2 arithmetic and the clamp, plus a sat flag. The top instantiates `NUM_CH` copies and owns valid, mode, enable and the counter.

## Test plan
- Sigmoid, acc = 0, bias = 0 → code 128 exactly 3 cycles after accept.
- Sigmoid with the following inputs, all with `sat_cnt` incremented per clamped lane:
  - acc = 163840 → 255 (saturate high);
  - acc = −98304 → 0 (saturate low);
  - bias = 128, acc = 0 → 140.
- Sigmoid, acc = −100, bias = 0 → 128. This checks truncation toward zero; a floor implementation gives 127.
- Alternating modes, acc = 16384, bias = 0:
  - sigmoid → 152, tanh → 176;
  - `out_mode` matches each beat.
- Back-to-back stream of 8 beats with `out_ready` toggling randomly → all 8 delivered in order, with no loss or duplication. Held outputs stay stable while stalled.
- Assert `rst` with 3 beats in flight → `out_valid` = 0 the next cycle. None of the 3 beats appears afterwards, and `sat_cnt` = 0.
